// File: rtl/canny_pkg.sv
// Shared definitions for the edge-detection pipeline: pixel width,
// quantised angle encodings and the Sobel window fill-state machine.
package canny_pkg;

    // Unsigned pixel / gradient magnitude width.
    localparam int BIT_LENGTH = 5;

    // Right shift applied to |Gx|+|Gy| before saturation.
    localparam int GRAD_SHIFT = 2;

    // Quantised gradient direction encodings.
    localparam logic [1:0] ANG_0   = 2'd0;  // horizontal gradient (vertical edge)
    localparam logic [1:0] ANG_45  = 2'd1;
    localparam logic [1:0] ANG_90  = 2'd2;  // vertical gradient (horizontal edge)
    localparam logic [1:0] ANG_135 = 2'd3;

    // How many columns of the current row are held in the sliding window.
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_TWO   = 2'd2,
        FILL_FULL  = 2'd3
    } fill_state_t;

    // Fill state after one more column is accepted; FULL saturates.
    function automatic fill_state_t fill_advance(input fill_state_t s);
        fill_state_t n;
        case (s)
            FILL_EMPTY: n = FILL_ONE;
            FILL_ONE:   n = FILL_TWO;
            default:    n = FILL_FULL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sobel_angle_quant.sv
// Combinational direction quantiser: maps a signed (Gx, Gy) pair onto one
// of four directions using fixed tan(22.5)/tan(67.5) ~ 2/5 and 5/2 bounds.
module sobel_angle_quant #(
    parameter int GW = canny_pkg::BIT_LENGTH + 4
) (
    input  logic signed [GW-1:0] gx,
    input  logic signed [GW-1:0] gy,
    output logic [1:0]           angle
);
    import canny_pkg::*;

    logic [GW-1:0] ax;
    logic [GW-1:0] ay;
    logic [GW+2:0] ax2;
    logic [GW+2:0] ay2;
    logic [GW+2:0] ax5;
    logic [GW+2:0] ay5;

    // Magnitudes and the scaled copies used by the ratio tests.
    always_comb begin
        ax  = gx[GW-1] ? (~gx + 1'b1) : gx;
        ay  = gy[GW-1] ? (~gy + 1'b1) : gy;
        ax2 = {2'b00, ax, 1'b0};
        ay2 = {2'b00, ay, 1'b0};
        ax5 = {3'b000, ax} + {1'b0, ax, 2'b00};
        ay5 = {3'b000, ay} + {1'b0, ay, 2'b00};
    end

    // Priority decision, first matching rule wins; a zero component is
    // treated as non-negative for the diagonal sign test.
    always_comb begin
        angle = ANG_135;
        if (ax == '0 && ay == '0) begin
            angle = ANG_0;
        end else if (ay5 < ax2) begin
            angle = ANG_0;
        end else if (ax5 < ay2) begin
            angle = ANG_90;
        end else if (gx[GW-1] == gy[GW-1]) begin
            angle = ANG_45;
        end else begin
            angle = ANG_135;
        end
    end

endmodule

// File: rtl/sobel_grad_unit.sv
// Streaming 3x3 Sobel stage. Accepts one 3-pixel column per enabled cycle,
// slides a 3-column window along the row and produces a saturated gradient
// magnitude plus a quantised direction for every complete window position.
//
// Interface: readable is a valid-only strobe with no back-pressure. It is
// high for exactly one cycle per result, and grad_out/angle_out are only
// meaningful in that cycle; the consumer must capture them then. Between
// results the outputs hold their previous value.
module sobel_grad_unit #(
    parameter int BIT_LENGTH = canny_pkg::BIT_LENGTH,
    parameter int GRAD_SHIFT = canny_pkg::GRAD_SHIFT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  row_start,
    input  logic                  enable,
    input  logic [BIT_LENGTH-1:0] pixel_in0,
    input  logic [BIT_LENGTH-1:0] pixel_in1,
    input  logic [BIT_LENGTH-1:0] pixel_in2,
    output logic [BIT_LENGTH-1:0] grad_out,
    output logic [1:0]            angle_out,
    output logic                  readable
);
    import canny_pkg::*;

    // Signed width for Gx/Gy: a weighted column sum is at most 4*max pixel.
    localparam int GW = BIT_LENGTH + 4;
    localparam logic [GW-1:0] PIX_MAX = GW'((1 << BIT_LENGTH) - 1);

    // Window columns. The incoming pixel_in column is the newest (R) of the
    // window being evaluated, win_r is the middle (M) and win_m the oldest
    // (L); after the shift they become L<=M, M<=R, R<=pixel_in. The column
    // that falls off the left is never needed again, so it is not stored.
    logic [BIT_LENGTH-1:0] win_m [3];
    logic [BIT_LENGTH-1:0] win_r [3];

    fill_state_t fill_state;
    fill_state_t fill_next;
    logic        qualify;

    // Stage 1: raw gradients of a qualifying window.
    logic                 s1_valid;
    logic signed [GW-1:0] s1_gx;
    logic signed [GW-1:0] s1_gy;
    logic signed [GW-1:0] gx_c;
    logic signed [GW-1:0] gy_c;

    // Stage 2 inputs derived from stage 1.
    logic [GW-1:0]         abs_gx;
    logic [GW-1:0]         abs_gy;
    logic [GW-1:0]         mag_sum;
    logic [GW-1:0]         mag_shr;
    logic [BIT_LENGTH-1:0] grad_sat;
    logic [1:0]            angle_q;

    // Weighted 1-2-1 sum of three unsigned pixels as a signed value.
    function automatic logic signed [GW-1:0] wsum(
        input logic [BIT_LENGTH-1:0] a,
        input logic [BIT_LENGTH-1:0] b,
        input logic [BIT_LENGTH-1:0] c
    );
        logic signed [GW-1:0] ea;
        logic signed [GW-1:0] eb;
        logic signed [GW-1:0] ec;
        ea = $signed({{(GW-BIT_LENGTH){1'b0}}, a});
        eb = $signed({{(GW-BIT_LENGTH){1'b0}}, b});
        ec = $signed({{(GW-BIT_LENGTH){1'b0}}, c});
        return ea + eb + eb + ec;
    endfunction

    // Fill state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_state <= FILL_EMPTY;
        end else begin
            fill_state <= fill_next;
        end
    end

    // Fill next-state and qualifying-beat decode. row_start restarts the
    // row; a column presented alongside it becomes the row's first column.
    always_comb begin
        fill_next = fill_state;
        qualify   = 1'b0;
        if (row_start) begin
            fill_next = enable ? FILL_ONE : FILL_EMPTY;
        end else if (enable) begin
            fill_next = fill_advance(fill_state);
            qualify   = (fill_state == FILL_TWO) || (fill_state == FILL_FULL);
        end
    end

    // Window shift register; contents only move on an enabled column.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                win_m[i] <= '0;
                win_r[i] <= '0;
            end
        end else if (enable) begin
            win_m <= win_r;
            win_r[0] <= pixel_in0;
            win_r[1] <= pixel_in1;
            win_r[2] <= pixel_in2;
        end
    end

    // Sobel kernels over (L=win_m, M=win_r, R=pixel_in), rows top..bottom.
    always_comb begin
        gx_c = wsum(pixel_in0, pixel_in1, pixel_in2) - wsum(win_m[0], win_m[1], win_m[2]);
        gy_c = wsum(win_m[2], win_r[2], pixel_in2) - wsum(win_m[0], win_r[0], pixel_in0);
    end

    // Stage 1 register: capture gradients only on a qualifying beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_gx    <= '0;
            s1_gy    <= '0;
        end else begin
            s1_valid <= qualify;
            if (qualify) begin
                s1_gx <= gx_c;
                s1_gy <= gy_c;
            end
        end
    end

    // L1 magnitude, scale-down and saturation to the pixel range.
    always_comb begin
        abs_gx   = s1_gx[GW-1] ? (~s1_gx + 1'b1) : s1_gx;
        abs_gy   = s1_gy[GW-1] ? (~s1_gy + 1'b1) : s1_gy;
        mag_sum  = abs_gx + abs_gy;
        mag_shr  = mag_sum >> GRAD_SHIFT;
        grad_sat = (mag_shr > PIX_MAX) ? PIX_MAX[BIT_LENGTH-1:0] : mag_shr[BIT_LENGTH-1:0];
    end

    sobel_angle_quant #(
        .GW(GW)
    ) u_angle_quant (
        .gx    (s1_gx),
        .gy    (s1_gy),
        .angle (angle_q)
    );

    // Stage 2 register: outputs update only with a valid result and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            readable  <= 1'b0;
            grad_out  <= '0;
            angle_out <= ANG_0;
        end else begin
            readable <= s1_valid;
            if (s1_valid) begin
                grad_out  <= grad_sat;
                angle_out <= angle_q;
            end
        end
    end

endmodule

// File: tb/tb_sobel_grad_unit.sv
module tb_sobel_grad_unit;

    localparam int EW = 39;  // {expected cycle[31:0], grad[4:0], angle[1:0]}

    logic       clk = 1'b0;
    logic       reset;
    logic       row_start;
    logic       enable;
    logic [4:0] pixel_in0;
    logic [4:0] pixel_in1;
    logic [4:0] pixel_in2;
    logic [4:0] grad_out;
    logic [1:0] angle_out;
    logic       readable;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int pulse_cnt = 0;

    logic [EW-1:0] exp_q[$];

    // Bench-side window model.
    int ml[3];
    int mm[3];
    int mr[3];
    int fill;

    sobel_grad_unit dut (
        .clk       (clk),
        .reset     (reset),
        .row_start (row_start),
        .enable    (enable),
        .pixel_in0 (pixel_in0),
        .pixel_in1 (pixel_in1),
        .pixel_in2 (pixel_in2),
        .grad_out  (grad_out),
        .angle_out (angle_out),
        .readable  (readable)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    function automatic void model_result(output int g, output int a);
        int gx, gy, ax, ay, s;
        gx = (mr[0] + 2 * mr[1] + mr[2]) - (ml[0] + 2 * ml[1] + ml[2]);
        gy = (ml[2] + 2 * mm[2] + mr[2]) - (ml[0] + 2 * mm[0] + mr[0]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        s  = (ax + ay) / 4;
        g  = (s > 31) ? 31 : s;
        if (ax == 0 && ay == 0)     a = 0;
        else if (5 * ay < 2 * ax)   a = 0;
        else if (5 * ax < 2 * ay)   a = 2;
        else if ((gx < 0) == (gy < 0)) a = 1;
        else                        a = 3;
    endfunction

    // ---------------- drivers ----------------
    task automatic col(input int a, input int b, input int c, input bit rs = 1'b0);
        int g, an;
        @(negedge clk);
        enable    = 1'b1;
        row_start = rs;
        pixel_in0 = 5'(a);
        pixel_in1 = 5'(b);
        pixel_in2 = 5'(c);
        if (rs) fill = 0;
        ml = mm;
        mm = mr;
        mr = '{a, b, c};
        if (fill >= 2) begin
            model_result(g, an);
            exp_q.push_back({32'(cyc + 2), 5'(g), 2'(an)});
        end
        if (fill < 3) fill++;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enable    = 1'b0;
            row_start = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic rs_only();
        @(negedge clk);
        enable    = 1'b0;
        row_start = 1'b1;
        fill      = 0;
        @(posedge clk);
    endtask

    task automatic expect_out(input string tag, input int g, input int a);
        @(negedge clk);
        check({tag, "_readable"}, 32'(readable), 1);
        check({tag, "_grad"}, 32'(grad_out), 32'(g));
        check({tag, "_angle"}, 32'(angle_out), 32'(a));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] ent;
        if (exp_q.size() > 0 && exp_q[0][38:7] == 32'(cyc)) begin
            ent = exp_q.pop_front();
            check("sb_readable", 32'(readable), 1);
            check("sb_grad", 32'(grad_out), 32'(ent[6:2]));
            check("sb_angle", 32'(angle_out), 32'(ent[1:0]));
            if (readable) pulse_cnt++;
        end else if (readable === 1'b1) begin
            check("spurious_readable", 32'(readable), 0);
            pulse_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        row_start = 1'b0;
        enable    = 1'b0;
        pixel_in0 = '0;
        pixel_in1 = '0;
        pixel_in2 = '0;
        fill      = 0;
        ml = '{0, 0, 0};
        mm = '{0, 0, 0};
        mr = '{0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_readable", 32'(readable), 0);
        check("reset_grad", 32'(grad_out), 0);
        check("reset_angle", 32'(angle_out), 0);
        reset = 1'b0;

        // 1: vertical edge, saturated magnitude, exact latency and hold
        col(0, 0, 0);
        col(0, 0, 0);
        col(31, 31, 31);
        @(negedge clk);
        enable = 1'b0;
        check("t1_early_readable", 32'(readable), 0);
        @(posedge clk);
        expect_out("t1", 31, 0);
        @(negedge clk);
        check("t1_hold_readable", 32'(readable), 0);
        check("t1_hold_grad", 32'(grad_out), 31);
        check("t1_hold_angle", 32'(angle_out), 0);

        // 2: horizontal edge
        col(0, 0, 8, 1'b1);
        col(0, 0, 8);
        col(0, 0, 8);
        idle(1);
        expect_out("t2", 8, 2);

        // 3: diagonal and its mirror
        col(0, 0, 0, 1'b1);
        col(0, 0, 4);
        col(0, 4, 4);
        idle(1);
        expect_out("t3", 6, 1);
        col(0, 4, 4, 1'b1);
        col(0, 0, 4);
        col(0, 0, 0);
        idle(1);
        expect_out("t3_mirror", 6, 3);

        // 4: row_start after 2 columns, then 3 columns -> one pulse
        idle(3);
        pulse_cnt = 0;
        col(5, 6, 7, 1'b1);
        col(9, 1, 3);
        rs_only();
        col(2, 4, 6);
        col(8, 8, 8);
        col(30, 1, 17);
        idle(4);
        check("t4_pulses", 32'(pulse_cnt), 1);

        // 4b: row_start right after a qualifying beat keeps the result
        pulse_cnt = 0;
        col(1, 2, 3, 1'b1);
        col(4, 5, 6);
        col(7, 8, 9);
        rs_only();
        idle(4);
        check("t4b_pulses", 32'(pulse_cnt), 1);

        // 5: enable every other cycle for 6 columns -> 4 pulses
        pulse_cnt = 0;
        col(3, 7, 1, 1'b1);   idle(1);
        col(10, 2, 31);       idle(1);
        col(0, 15, 4);        idle(1);
        col(20, 20, 0);       idle(1);
        col(6, 9, 12);        idle(1);
        col(31, 0, 5);        idle(4);
        check("t5_pulses", 32'(pulse_cnt), 4);

        // 6: reset with both pipeline stages valid
        col(2, 2, 2, 1'b1);
        col(9, 4, 0);
        col(31, 0, 0);
        col(0, 31, 0);
        col(17, 3, 25);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        exp_q.delete();
        fill = 0;
        @(negedge clk);
        check("t6_readable", 32'(readable), 0);
        check("t6_grad", 32'(grad_out), 0);
        check("t6_angle", 32'(angle_out), 0);
        reset = 1'b0;
        pulse_cnt = 0;
        col(1, 1, 1);
        col(2, 2, 2);
        idle(4);
        check("t6_no_pulse", 32'(pulse_cnt), 0);
        col(3, 3, 3);
        idle(1);
        expect_out("t6_refill", 2, 0);
        idle(3);

        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
